// File: rtl/serial_cmp.sv
// Serial bit-pair comparator: shifts in W pairs of (x, y) after a start request
// and reports equality, the mismatch count and the index of the first mismatch.
module serial_cmp #(
    parameter int W  = 8,
    parameter int CW = 4,
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          x,
    input  logic          y,
    output logic          busy,
    output logic          done,
    output logic          eq,
    output logic [CW-1:0] mcnt,
    output logic [PW-1:0] fpos
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int BW = (W > 1) ? $clog2(W) : 1;

    logic [1:0]    state;
    logic [BW-1:0] bit_idx;
    logic          mismatch;
    logic          last_bit;
    logic [CW-1:0] mcnt_next;

    assign mismatch  = x ^ y;
    assign last_bit  = (bit_idx == BW'(W - 1));
    assign mcnt_next = mcnt + CW'(mismatch);

    // busy and done are flops of their own so every output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            mcnt    <= '0;
            fpos    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every branch read the pre-edge mcnt.
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        bit_idx <= '0;
                        mcnt    <= '0;
                        fpos    <= '0;
                        eq      <= 1'b0;
                    end
                end
                SHIFT: begin
                    mcnt <= mcnt_next;
                    // A zero count so far means this is the first mismatch of the frame.
                    if (mismatch && (mcnt == '0)) begin
                        fpos <= PW'(bit_idx);
                    end
                    if (last_bit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        eq    <= (mcnt_next == '0);
                    end else begin
                        bit_idx <= bit_idx + BW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
